rle_compressor: RTL
===================

RLE_COMPRESSOR -- requirements
Module: rle_compressor

Interface
REQ-001 SHALL have no parameters; data word width fixed at 16, run counter fixed at 16 bits.
REQ-002 SHALL provide port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port Din  input  16  raw bitmap word; bit 0 scanned first, bit 15 last.
REQ-005 SHALL provide port din_valid  input  1  Din/last valid.
REQ-006 SHALL provide port din_ready  output  1  block accepts Din; transfer on din_valid & din_ready at a clk edge.
REQ-007 SHALL provide port last  input  1  qualifies the accepted word as the final word of the frame.
REQ-008 SHALL provide port Dout  output  16  compressed word (header or run length).
REQ-009 SHALL provide port dout_valid  output  1  Dout valid.
REQ-010 SHALL provide port dout_ready  input  1  consumer (DMA) accepts Dout; transfer on dout_valid & dout_ready.
REQ-011 SHALL provide port done  output  1  one-cycle pulse when the frame's final run is transferred.

Function
REQ-012 SHALL emit a stream decodable by the team's run-length decompressor: header word {15'b0, first_bit}, then run lengths alternating in bit value starting with first_bit.
REQ-013 SHALL implement states IDLE, HEADER, SCAN, EMIT, ZERO, WAIT, FLUSH.
REQ-014 IDLE: din_ready=1; on transfer latch word and last flag, cur_bit<=Din[0], run<=0, idx<=0, go HEADER.
REQ-015 HEADER: dout_valid=1, Dout={15'b0,cur_bit}; on dout_ready go SCAN.
REQ-016 SCAN: examines one bit b=word[idx] per cycle; din_ready=0, dout_valid=0.
REQ-017 SCAN, b==cur_bit and run<65535: run<=run+1, advance idx.
REQ-018 SCAN, b!=cur_bit: go EMIT with Dout=run; on transfer cur_bit<=b, run<=1, advance idx.
REQ-019 SCAN, b==cur_bit and run==65535: EMIT 65535, then ZERO emits 0x0000 (zero-length run of opposite value); on its transfer run<=1, advance idx; cur_bit unchanged.
REQ-020 Advance idx: idx<15 -> idx+1, SCAN; idx==15 and latched last=1 -> FLUSH; else -> WAIT.
REQ-021 WAIT: din_ready=1; on transfer latch word and last, idx<=0, go SCAN; run and cur_bit carry across words.
REQ-022 FLUSH: dout_valid=1, Dout=run; on transfer pulse done=1 for exactly one cycle, go IDLE.
REQ-023 Dout SHALL hold stable while dout_valid=1 and dout_ready=0; no word lost or duplicated under any backpressure.
REQ-024 din_ready SHALL be 1 only in IDLE and WAIT; din_valid outside those states is ignored.
REQ-025 Latency: header valid the cycle after first-word transfer; with dout_ready=1 each word costs 16 SCAN cycles plus one cycle per emitted run.
REQ-026 Run value SHALL never exceed 65535 nor wrap to 0 except via REQ-019.

Reset
REQ-027 rst=1 at a clk edge SHALL force IDLE, Dout=0x0000, dout_valid=0, done=0, run=0, idx=0, cur_bit=0; din_ready=1 from the next cycle.
REQ-028 rst SHALL take priority over every handshake in the same cycle; a frame interrupted by reset is discarded, no flush emitted.

Verification
REQ-029 Single word 0x00FF, last=1, dout_ready=1 -> Dout sequence 0x0001, 0x0008, 0x0008; done pulses once with last transfer.
REQ-030 Words 0x0000, 0x0000 (last on second) -> 0x0000, 0x0020; no run emitted at word boundary.
REQ-031 Word 0xAAAA, last=1 -> 0x0000 then sixteen 0x0001 words.
REQ-032 4096 words 0xFFFF, last on final -> 0x0001, 0xFFFF, 0x0000, 0x0001.
REQ-033 0x00FF, last=1, dout_ready low 5 cycles while Dout=0x0008 -> Dout and dout_valid held, sequence identical to REQ-029.
REQ-034 rst asserted mid-SCAN of second word -> next cycle dout_valid=0, done=0, din_ready=1; new frame 0x00FF yields REQ-029 output exactly.

Source files
------------

// File: rtl/rle_compressor_if.sv
// Stream signals of the run-length compressor: raw bitmap words in, compressed words out.
interface rle_compressor_if;
   logic [15:0] Din;
   logic        din_valid;
   logic        din_ready;
   logic        last;
   logic [15:0] Dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        done;

   modport slave (
      input  Din, din_valid, last, dout_ready,
      output din_ready, Dout, dout_valid, done
   );

   modport master (
      output Din, din_valid, last, dout_ready,
      input  din_ready, Dout, dout_valid, done
   );
endinterface

// File: rtl/rle_compressor.sv
// Bitmap run-length compressor: emits a header with the first bit value, then
// alternating run lengths; runs longer than 65535 are split by a zero-length run.
module rle_compressor (
   input  logic            clk,
   input  logic            rst,
   rle_compressor_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_HEADER = 3'd1;
   localparam logic [2:0] S_SCAN   = 3'd2;
   localparam logic [2:0] S_EMIT   = 3'd3;
   localparam logic [2:0] S_ZERO   = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;
   localparam logic [2:0] S_FLUSH  = 3'd6;

   localparam logic [15:0] RUN_MAX = 16'hFFFF;

   logic [2:0]  r_state;
   logic [15:0] r_word;
   logic [15:0] r_run;
   logic [15:0] r_dout;
   logic [3:0]  r_idx;
   logic        r_last;
   logic        r_cur_bit;
   logic        r_sat;
   logic        r_done;

   logic        w_bit;
   logic        w_in_xfer;
   logic        w_adv;
   logic [15:0] w_adv_run;
   logic [2:0]  w_adv_state;

   assign w_bit       = r_word[r_idx];
   assign w_in_xfer   = bus.din_valid && bus.din_ready;
   assign w_adv_run   = (r_state == S_SCAN) ? r_run + 16'd1 : 16'd1;
   assign w_adv_state = (r_idx != 4'd15) ? S_SCAN : (r_last ? S_FLUSH : S_WAIT);

   assign bus.din_ready  = (r_state == S_IDLE) || (r_state == S_WAIT);
   assign bus.dout_valid = (r_state == S_HEADER) || (r_state == S_EMIT) ||
                           (r_state == S_ZERO)   || (r_state == S_FLUSH);
   assign bus.Dout       = r_dout;
   assign bus.done       = r_done;

   // Cycles that consume the current bit and move idx forward.
   always_comb begin
      w_adv = 1'b0;
      case (r_state)
         S_SCAN:  w_adv = (w_bit == r_cur_bit) && (r_run != RUN_MAX);
         S_EMIT:  w_adv = bus.dout_ready && !r_sat;
         S_ZERO:  w_adv = bus.dout_ready;
         default: w_adv = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_word    <= '0;
         r_run     <= '0;
         r_dout    <= '0;
         r_idx     <= '0;
         r_last    <= 1'b0;
         r_cur_bit <= 1'b0;
         r_sat     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_in_xfer) begin
                  r_word    <= bus.Din;
                  r_last    <= bus.last;
                  r_cur_bit <= bus.Din[0];
                  r_run     <= '0;
                  r_idx     <= '0;
                  r_dout    <= {15'b0, bus.Din[0]};
                  r_state   <= S_HEADER;
               end
            end
            S_HEADER: if (bus.dout_ready) r_state <= S_SCAN;
            S_SCAN: begin
               if (w_bit != r_cur_bit) begin
                  r_dout  <= r_run;
                  r_sat   <= 1'b0;
                  r_state <= S_EMIT;
               end else if (r_run == RUN_MAX) begin
                  r_dout  <= RUN_MAX;
                  r_sat   <= 1'b1;
                  r_state <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (bus.dout_ready) begin
                  if (r_sat) begin
                     r_dout  <= '0;
                     r_state <= S_ZERO;
                  end else begin
                     r_cur_bit <= w_bit;
                  end
               end
            end
            S_WAIT: begin
               if (w_in_xfer) begin
                  r_word  <= bus.Din;
                  r_last  <= bus.last;
                  r_idx   <= '0;
                  r_state <= S_SCAN;
               end
            end
            S_FLUSH: begin
               if (bus.dout_ready) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // NOTE: the last non-blocking assignment in a block wins, so this shared
         // advance path overrides whatever the per-state case wrote above.
         if (w_adv) begin
            r_run   <= w_adv_run;
            r_idx   <= r_idx + 4'd1;
            r_dout  <= w_adv_run;
            r_state <= w_adv_state;
         end
      end
   end
endmodule
